capture_readout: RTL

CAPTURE_READOUT -- requirements
Module: capture_readout

---
 rtl/capture_readout_pkg.sv | 29 ++
 rtl/capture_readout_fifo.sv | 65 ++++++
 rtl/capture_readout.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/capture_readout_pkg.sv
// Shared definitions for the capture readout path: FSM states, address step,
// and the A/B field layout that the capture writer also uses.
package capture_readout_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Capture memory is word addressed in bytes.
   localparam logic [31:0] ADDR_STEP = 32'd4;

   // Field positions inside one capture word.
   localparam int A_LSB = 0;
   localparam int A_W   = 14;
   localparam int B_LSB = 16;
   localparam int B_W   = 14;

   // Turn a raw capture word into the stream format {sext(B), sext(A)}.
   function automatic logic [31:0] format_sample(input logic [31:0] word);
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      a = word[A_LSB +: A_W];
      b = word[B_LSB +: B_W];
      return {{(16-B_W){b[B_W-1]}}, b, {(16-A_W){a[A_W-1]}}, a};
   endfunction

endpackage

// File: rtl/capture_readout_fifo.sv
// Return buffer for capture readout: synchronous first-word-fall-through FIFO.
// A simultaneous push and pop keeps occupancy unchanged, also when full.
module readout_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             wr_ok, rd_ok;

   // Push/pop qualification and next pointer/occupancy values.
   always_comb begin
      rd_ok    = rd_en && (count_q != '0);
      wr_ok    = wr_en && ((count_q != FULL_CNT) || rd_ok);
      wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are qualified by occupancy, so no reset needed.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   // Head entry is presented as zero while empty so outputs are clean after reset.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/capture_readout.sv
// Capture readout: streams (max_sample_cnt+1)*max_repetition_cnt words from
// capture memory, reformats each into {sext(B), sext(A)}, and marks the last
// sample of every repetition. Reads are credit-limited against the return FIFO.
module capture_readout
   import capture_readout_pkg::*;
#(
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [23:0] max_sample_cnt,
   input  logic [23:0] max_repetition_cnt,
   output logic        rd_en,
   output logic [31:0] rd_address,
   input  logic [31:0] rd_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,
   output logic        busy,
   output logic        done
);

   state_t                   state_q, state_d;
   logic [31:0]              addr_q, addr_d;
   logic [23:0]              samp_q, samp_d;
   logic [23:0]              rep_q, rep_d;
   logic [23:0]              max_s_q, max_s_d;
   logic [23:0]              max_r_q, max_r_d;
   logic                     zero_done_q, zero_done_d;
   logic [RD_LATENCY-1:0]    vld_sr_q, vld_sr_d;
   logic [RD_LATENCY-1:0]    last_sr_q, last_sr_d;
   logic [2:0]               out_cnt;
   logic                     credit_ok;
   logic                     word_last, final_word;
   logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [32:0]              fifo_wdata, fifo_rdata;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   // Count reads in flight and grant a new read only if its return has a slot.
   always_comb begin
      out_cnt = '0;
      for (int i = 0; i < RD_LATENCY; i++) out_cnt = out_cnt + 3'(vld_sr_q[i]);
      credit_ok = !fifo_full && ((int'(out_cnt) + int'(fifo_count)) < FIFO_DEPTH);
   end

   // Readout FSM: start handling, address/counter advance and completion.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      samp_d      = samp_q;
      rep_d       = rep_q;
      max_s_d     = max_s_q;
      max_r_d     = max_r_q;
      zero_done_d = 1'b0;
      rd_en       = 1'b0;
      done        = zero_done_q;
      word_last   = (samp_q == max_s_q);
      final_word  = word_last && (rep_q == max_r_q - 24'd1);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (max_repetition_cnt != 24'd0) begin
                  state_d = ST_READ;
                  addr_d  = '0;
                  samp_d  = '0;
                  rep_d   = '0;
                  max_s_d = max_sample_cnt;
                  max_r_d = max_repetition_cnt;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (credit_ok) begin
               rd_en  = 1'b1;
               addr_d = addr_q + ADDR_STEP;
               if (word_last) begin
                  samp_d = '0;
                  rep_d  = rep_q + 24'd1;
               end else begin
                  samp_d = samp_q + 24'd1;
               end
               if (final_word) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((out_cnt == '0) && fifo_empty) begin
               state_d = ST_IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // In-flight tracking: one slot per latency cycle, carrying the end-of-repetition mark.
   always_comb begin
      vld_sr_d[0]  = rd_en;
      last_sr_d[0] = rd_en && word_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_sr_d[i]  = vld_sr_q[i-1];
         last_sr_d[i] = last_sr_q[i-1];
      end
   end

   // Control and tracking registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         samp_q      <= '0;
         rep_q       <= '0;
         max_s_q     <= '0;
         max_r_q     <= '0;
         zero_done_q <= 1'b0;
         vld_sr_q    <= '0;
         last_sr_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         samp_q      <= samp_d;
         rep_q       <= rep_d;
         max_s_q     <= max_s_d;
         max_r_q     <= max_r_d;
         zero_done_q <= zero_done_d;
         vld_sr_q    <= vld_sr_d;
         last_sr_q   <= last_sr_d;
      end
   end

   assign fifo_push  = vld_sr_q[RD_LATENCY-1];
   assign fifo_wdata = {last_sr_q[RD_LATENCY-1], format_sample(rd_data)};
   assign fifo_pop   = m_valid && m_ready;

   readout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (33)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_push),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign m_valid    = !fifo_empty;
   assign m_last     = fifo_rdata[32];
   assign m_data     = fifo_rdata[31:0];
   assign rd_address = addr_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
